// File: rtl/bitnet_pkg.sv
// Shared definitions for the bitnet host-link path: command codes,
// BRAM write-select encoding and the packet decoder state machine.
package bitnet_pkg;

  localparam logic [7:0] CMD_WR_DATA   = 8'h00;
  localparam logic [7:0] CMD_WR_WEIGHT = 8'h01;
  localparam logic [7:0] CMD_WR_OP     = 8'h03;
  localparam logic [7:0] CMD_RD_DATA   = 8'h04;

  typedef enum logic [1:0] {
    SEL_DATA   = 2'd0,
    SEL_WEIGHT = 2'd1,
    SEL_OP     = 2'd3
  } wr_sel_e;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_PAYLOAD,
    ST_RDREQ
  } dec_state_e;

  function automatic logic is_wr_cmd(input logic [7:0] cmd);
    return (cmd == CMD_WR_DATA) || (cmd == CMD_WR_WEIGHT) || (cmd == CMD_WR_OP);
  endfunction

  function automatic wr_sel_e cmd_to_sel(input logic [7:0] cmd);
    case (cmd)
      CMD_WR_WEIGHT: return SEL_WEIGHT;
      CMD_WR_OP:     return SEL_OP;
      default:       return SEL_DATA;
    endcase
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs payload bytes LSB-first into a word. Byte 0 of each word clears the
// whole register so bits above the selected width read back as zero; the
// completed word stays on `word` until the next word's first byte arrives.
module word_assembler #(
  parameter int WORD_W = 96,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [7:0]        din,
  input  logic [IDX_W-1:0]  bytes_per_word,
  output logic [WORD_W-1:0] word,
  output logic              last_byte,
  output logic              word_done
);

  localparam int NB = WORD_W / 8;

  logic [IDX_W-1:0] idx;

  assign last_byte = byte_valid && (idx == bytes_per_word - 1'b1);

  // Byte-index counter, lane insert and one-cycle completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      word      <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= last_byte && !clr;
      if (clr) begin
        idx <= '0;
      end else if (byte_valid) begin
        idx <= last_byte ? '0 : idx + 1'b1;
        for (int b = 0; b < NB; b++) begin
          if (b == int'(idx))      word[8*b +: 8] <= din;
          else if (idx == '0)      word[8*b +: 8] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/uart_packet_decoder.sv
// Host byte-stream decoder: 3-byte header (cmd, count lo, count hi) then
// payload words written to data/weight/op BRAMs, or a readback request.
// Optional inter-byte idle timeout: define PKT_TIMEOUT_EN.
module uart_packet_decoder
  import bitnet_pkg::*;
#(
  parameter int DATA_SIZE      = 64,
  parameter int WEIGHT_SIZE    = 96,
  parameter int OP_SIZE        = 8,
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   byte_valid_in,
  input  logic [7:0]             byte_in,
  output logic                   wr_en_out,
  output logic [1:0]             wr_sel_out,
  output logic [ADDR_W-1:0]      wr_addr_out,
  output logic [WEIGHT_SIZE-1:0] wr_data_out,
  output logic                   rd_req_valid_out,
  input  logic                   rd_req_ready_in,
  output logic [15:0]            rd_count_out,
  output logic                   busy_out,
  output logic                   err_out
);

  localparam int IDX_W = $clog2(WEIGHT_SIZE/8 + 1);
  localparam logic [IDX_W-1:0] BPW_DATA   = IDX_W'(DATA_SIZE/8);
  localparam logic [IDX_W-1:0] BPW_WEIGHT = IDX_W'(WEIGHT_SIZE/8);
  localparam logic [IDX_W-1:0] BPW_OP     = IDX_W'(OP_SIZE/8);

  dec_state_e        state_q, state_d;
  logic [7:0]        cmd_q;
  logic [15:0]       count_q;
  logic [15:0]       word_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  wr_sel_e           sel_q;
  logic              err_q;
  logic [IDX_W-1:0]  bpw;
  logic              pay_valid, last_byte, word_done, timeout, asm_clr;

  assign pay_valid = byte_valid_in && (state_q == ST_PAYLOAD);
  assign asm_clr   = ((state_q == ST_HDR2) && byte_valid_in) || timeout;

`ifdef PKT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Idle counter: runs while busy, cleared by every byte, saturates.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                                   to_cnt <= '0;
    else if (!busy_out || byte_valid_in)           to_cnt <= '0;
    else if (to_cnt != TO_W'(TIMEOUT_CYCLES))      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = !byte_valid_in && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) &&
                   (state_q inside {ST_HDR1, ST_HDR2, ST_PAYLOAD});
`else
  assign timeout = 1'b0;
`endif

  // Bytes-per-word for the active write target.
  always_comb begin
    bpw = BPW_DATA;
    case (sel_q)
      SEL_WEIGHT: bpw = BPW_WEIGHT;
      SEL_OP:     bpw = BPW_OP;
      default:    bpw = BPW_DATA;
    endcase
  end

  word_assembler #(.WORD_W(WEIGHT_SIZE), .IDX_W(IDX_W)) u_asm (
    .clk            (clk_in),
    .rst_n          (rst_in),
    .clr            (asm_clr),
    .byte_valid     (pay_valid),
    .din            (byte_in),
    .bytes_per_word (bpw),
    .word           (wr_data_out),
    .last_byte      (last_byte),
    .word_done      (word_done)
  );

  // Next-state decode; the last byte of the last word returns to HDR0 so a
  // header byte landing in the strobe cycle is parsed normally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR0: if (byte_valid_in) state_d = ST_HDR1;
      ST_HDR1: if (byte_valid_in) state_d = ST_HDR2;
      ST_HDR2: if (byte_valid_in) begin
        if (is_wr_cmd(cmd_q))          state_d = ST_PAYLOAD;
        else if (cmd_q == CMD_RD_DATA) state_d = ST_RDREQ;
        else                           state_d = ST_HDR0;
      end
      ST_PAYLOAD: if (last_byte && (word_cnt_q == count_q)) state_d = ST_HDR0;
      ST_RDREQ:   if (rd_req_ready_in) state_d = ST_HDR0;
      default:    state_d = ST_HDR0;
    endcase
    if (timeout) state_d = ST_HDR0;
  end

  // State, header fields, word/address counters and sticky error.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_HDR0;
      cmd_q      <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      sel_q      <= SEL_DATA;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (timeout) err_q <= 1'b1;
      if (word_done) addr_q <= addr_q + 1'b1;
      case (state_q)
        ST_HDR0: if (byte_valid_in) cmd_q <= byte_in;
        ST_HDR1: if (byte_valid_in) count_q[7:0] <= byte_in;
        ST_HDR2: if (byte_valid_in) begin
          count_q[15:8] <= byte_in;
          if (is_wr_cmd(cmd_q)) begin
            sel_q      <= cmd_to_sel(cmd_q);
            addr_q     <= '0;
            word_cnt_q <= '0;
          end else if (cmd_q != CMD_RD_DATA) begin
            err_q <= 1'b1;
          end
        end
        ST_PAYLOAD: if (last_byte) word_cnt_q <= word_cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign wr_en_out        = word_done;
  assign wr_sel_out       = sel_q;
  assign wr_addr_out      = addr_q;
  assign rd_req_valid_out = (state_q == ST_RDREQ);
  assign rd_count_out     = count_q;
  assign busy_out         = (state_q != ST_HDR0);
  assign err_out          = err_q;

endmodule

// File: tb/tb_uart_packet_decoder.sv
// Directed bench for uart_packet_decoder: table of write packets plus
// hand-written readback, bad-command, reset-abort, wrap and timeout cases.
module tb_uart_packet_decoder;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_d = '0;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [11:0] wr_addr;
  logic [95:0] wr_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [15:0] rd_count;
  logic        busy, err;

  int checks = 0;
  int errors = 0;
  int n_strobe = 0;
  logic [11:0] last_addr;
  logic [95:0] last_data;

  always #5 clk = ~clk;

  uart_packet_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .byte_valid_in    (byte_valid),
    .byte_in          (byte_d),
    .wr_en_out        (wr_en),
    .wr_sel_out       (wr_sel),
    .wr_addr_out      (wr_addr),
    .wr_data_out      (wr_data),
    .rd_req_valid_out (rd_valid),
    .rd_req_ready_in  (rd_ready),
    .rd_count_out     (rd_count),
    .busy_out         (busy),
    .err_out          (err)
  );

  // Strobe monitor.
  always @(negedge clk) begin
    if (wr_en) begin
      n_strobe++;
      last_addr = wr_addr;
      last_data = wr_data;
    end
  end

  typedef struct {
    int               nb;
    logic [19:0][7:0] b;
    logic [19:0]      mask;
    int               ns;
    logic [1:0][1:0]  sel;
    logic [1:0][11:0] addr;
    logic [1:0][95:0] data;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_d     = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int base, s;

    // Op write, one word.
    vecs[0] = '{nb: 4, b: '0, mask: '0, ns: 1, sel: '0, addr: '0, data: '0};
    vecs[0].b[0] = 8'h03; vecs[0].b[3] = 8'h05;
    vecs[0].mask[3] = 1'b1;
    vecs[0].sel[0] = 2'd3; vecs[0].data[0] = 96'h05;
    // Data write, two words.
    vecs[1] = '{nb: 19, b: '0, mask: '0, ns: 2, sel: '0, addr: '0, data: '0};
    vecs[1].b[1] = 8'h01;
    for (int i = 0; i < 16; i++) vecs[1].b[3+i] = 8'(8'h36 + i);
    vecs[1].mask[10] = 1'b1; vecs[1].mask[18] = 1'b1;
    vecs[1].addr[1] = 12'd1;
    vecs[1].data[0] = 96'h3D3C3B3A39383736;
    vecs[1].data[1] = 96'h4544434241403F3E;
    // Weight write, full 96-bit word.
    vecs[2] = '{nb: 15, b: '0, mask: '0, ns: 1, sel: '0, addr: '0, data: '0};
    vecs[2].b[0] = 8'h01;
    for (int i = 0; i < 12; i++) vecs[2].b[3+i] = 8'(i + 1);
    vecs[2].mask[14] = 1'b1;
    vecs[2].sel[0] = 2'd1; vecs[2].data[0] = 96'h0C0B0A090807060504030201;
    // Op write, two words back-to-back (byte lands in strobe cycle).
    vecs[3] = '{nb: 5, b: '0, mask: '0, ns: 2, sel: '0, addr: '0, data: '0};
    vecs[3].b[0] = 8'h03; vecs[3].b[1] = 8'h01; vecs[3].b[3] = 8'hAA; vecs[3].b[4] = 8'hBB;
    vecs[3].mask[3] = 1'b1; vecs[3].mask[4] = 1'b1;
    vecs[3].sel[0] = 2'd3; vecs[3].sel[1] = 2'd3; vecs[3].addr[1] = 12'd1;
    vecs[3].data[0] = 96'hAA; vecs[3].data[1] = 96'hBB;

    // Reset state.
    idle(3);
    chk("rst_wr_en", 96'(wr_en), 96'd0);
    chk("rst_sel", 96'(wr_sel), 96'd0);
    chk("rst_addr", 96'(wr_addr), 96'd0);
    chk("rst_data", wr_data, 96'd0);
    chk("rst_rd_valid", 96'(rd_valid), 96'd0);
    chk("rst_rd_count", 96'(rd_count), 96'd0);
    chk("rst_busy", 96'(busy), 96'd0);
    chk("rst_err", 96'(err), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Table-driven write packets.
    for (int v = 0; v < 4; v++) begin
      base = n_strobe;
      s = 0;
      for (int i = 0; i < vecs[v].nb; i++) begin
        send(vecs[v].b[i]);
        chk($sformatf("v%0d_b%0d_wr_en", v, i), 96'(wr_en), 96'(vecs[v].mask[i]));
        if (vecs[v].mask[i]) begin
          chk($sformatf("v%0d_s%0d_sel", v, s), 96'(wr_sel), 96'(vecs[v].sel[s]));
          chk($sformatf("v%0d_s%0d_addr", v, s), 96'(wr_addr), 96'(vecs[v].addr[s]));
          chk($sformatf("v%0d_s%0d_data", v, s), wr_data, vecs[v].data[s]);
          s++;
        end
      end
      chk($sformatf("v%0d_busy_end", v), 96'(busy), 96'd0);
      idle(2);
      chk($sformatf("v%0d_nstrobe", v), 96'(n_strobe - base), 96'(vecs[v].ns));
      chk($sformatf("v%0d_held_data", v), wr_data, vecs[v].data[vecs[v].ns-1]);
      chk($sformatf("v%0d_err", v), 96'(err), 96'd0);
    end

    // Readback with ready held low; a stray byte during RDREQ is dropped.
    base = n_strobe;
    send(8'h04); send(8'h02); send(8'h00);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rd_valid_%0d", k), 96'(rd_valid), 96'd1);
      chk($sformatf("rd_count_%0d", k), 96'(rd_count), 96'd2);
      chk($sformatf("rd_busy_%0d", k), 96'(busy), 96'd1);
      if (k == 2) send(8'hFF);
      else @(negedge clk);
    end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    chk("rd_valid_clr", 96'(rd_valid), 96'd0);
    chk("rd_busy_clr", 96'(busy), 96'd0);
    send(8'h03); send(8'h00); send(8'h00); send(8'h11);
    chk("post_rd_wr_en", 96'(wr_en), 96'd1);
    chk("post_rd_data", wr_data, 96'h11);
    idle(2);
    chk("rd_nstrobe", 96'(n_strobe - base), 96'd1);

    // Unknown command: sticky error, no payload consumed.
    base = n_strobe;
    send(8'h07); send(8'h00); send(8'h00);
    chk("bad_err", 96'(err), 96'd1);
    chk("bad_busy", 96'(busy), 96'd0);
    send(8'h03); send(8'h00); send(8'h00); send(8'h09);
    chk("bad_next_wr_en", 96'(wr_en), 96'd1);
    chk("bad_next_addr", 96'(wr_addr), 96'd0);
    chk("bad_next_data", wr_data, 96'h09);
    idle(2);
    chk("bad_nstrobe", 96'(n_strobe - base), 96'd1);
    chk("bad_err_sticky", 96'(err), 96'd1);

    // Reset mid-payload aborts the partial word.
    base = n_strobe;
    send(8'h00); send(8'h00); send(8'h00);
    send(8'h21); send(8'h22); send(8'h23);
    rst_n = 1'b0;
    idle(2);
    chk("rst_mid_busy", 96'(busy), 96'd0);
    chk("rst_mid_err", 96'(err), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("rst_mid_nstrobe", 96'(n_strobe - base), 96'd0);
    send(8'h03); send(8'h00); send(8'h00); send(8'h77);
    chk("rst_after_wr_en", 96'(wr_en), 96'd1);
    chk("rst_after_sel", 96'(wr_sel), 96'd3);
    chk("rst_after_data", wr_data, 96'h77);
    idle(2);

    // Address wrap: 4097 op words, last lands back at address 0.
    base = n_strobe;
    send(8'h03); send(8'h00); send(8'h10);
    for (int i = 0; i <= 4096; i++) send(8'(i) ^ 8'h5A);
    idle(2);
    chk("wrap_nstrobe", 96'(n_strobe - base), 96'd4097);
    chk("wrap_last_addr", 96'(last_addr), 96'd0);
    chk("wrap_last_data", last_data, 96'h5A);
    chk("wrap_busy", 96'(busy), 96'd0);

`ifdef PKT_TIMEOUT_EN
    // Stall mid-payload: returns to HDR0 with error, no strobe.
    base = n_strobe;
    send(8'h00); send(8'h00); send(8'h00); send(8'h11); send(8'h22);
    idle(TO - 5);
    chk("to_busy_before", 96'(busy), 96'd1);
    chk("to_err_before", 96'(err), 96'd0);
    idle(10);
    chk("to_busy_after", 96'(busy), 96'd0);
    chk("to_err_after", 96'(err), 96'd1);
    chk("to_nstrobe", 96'(n_strobe - base), 96'd0);
    send(8'h03); send(8'h00); send(8'h00); send(8'h44);
    chk("to_next_data", wr_data, 96'h44);
    idle(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_packet_decoder.md
Name: uart_packet_decoder

Overview:
- Sits directly downstream of the UART receiver and upstream of the data/weight/op BRAM write ports and the readback serializer in the bitnet CPU top level.
- Parses the host byte stream into 3-byte headers plus payload.
- Assembles payload bytes LSB-first into words of the width selected by the command.
- Issues single-cycle BRAM write strobes with auto-incrementing addresses, or a readback request.

Parameters:
- DATA_SIZE, 64, data BRAM word width in bits (multiple of 8)
- WEIGHT_SIZE, 96, weight BRAM word width in bits (multiple of 8)
- OP_SIZE, 8, op BRAM word width in bits (multiple of 8)
- ADDR_W, 12, write/read address width
- TIMEOUT_CYCLES, 100000, inter-byte idle limit (used only with the optional feature)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-low reset
- byte_valid_in  input  1  one-cycle pulse, new received byte
- byte_in  input  8  received byte
- wr_en_out  output  1  one-cycle write strobe
- wr_sel_out  output  2  write target: 0 data, 1 weight, 3 op
- wr_addr_out  output  ADDR_W  write address
- wr_data_out  output  WEIGHT_SIZE  assembled word, zero-extended above the selected width
- rd_req_valid_out  output  1  readback request valid
- rd_req_ready_in  input  1  serializer accepts request
- rd_count_out  output  16  number of data words to read back, minus 1
- busy_out  output  1  high in any state other than HDR0
- err_out  output  1  sticky: unknown command seen; cleared only by reset

Behaviour:
- Reset: all outputs 0; state HDR0; address and byte counters 0.
- Header byte order: byte0 = cmd, byte1 = count[7:0], byte2 = count[15:8].
  - count is the number of words minus 1, so 0 means one word.
- States:
  - HDR0: on byte, latch cmd, go to HDR1.
  - HDR1: on byte, latch count low byte, go to HDR2.
  - HDR2: on byte, latch count high byte, then decode cmd:
    - 0x00, 0x01, 0x03 -> PAYLOAD; word address and byte index cleared.
    - 0x04 -> RDREQ.
    - Any other cmd -> set err_out, return to HDR0; no payload is consumed.
  - PAYLOAD: each byte is shifted into bit position 8*byte_idx.
    - Bytes per word: DATA_SIZE/8 for cmd 0, WEIGHT_SIZE/8 for cmd 1, OP_SIZE/8 for cmd 3.
    - On the last byte of a word, wr_en_out pulses on the next cycle with wr_addr_out = current address and the completed word; the address then increments.
    - After word number count+1 is written, return to HDR0.
  - RDREQ: rd_req_valid_out high with rd_count_out = count.
    - rd_count_out is held stable until rd_req_ready_in is sampled high; that cycle returns to HDR0.
    - Bytes arriving during RDREQ are dropped.
- Latency: last byte of a word to wr_en_out is exactly 1 cycle.
- Address wraps modulo 2^ADDR_W; there is no error on wrap.
- The word register is cleared at the start of each word, so upper unused bits are 0.
- byte_valid_in arriving in the same cycle as wr_en_out is accepted normally; back-to-back bytes on consecutive cycles are legal.
- Reset asserted mid-packet aborts the packet immediately.
  - No wr_en_out is issued for a partial word.
  - A pending read request is dropped.
- wr_sel_out and wr_data_out are held between strobes.

Optional Feature:
- Macro: PKT_TIMEOUT_EN.
- Defined: a counter runs while busy_out is high and clears on each byte_valid_in.
  - On reaching TIMEOUT_CYCLES in HDR1, HDR2 or PAYLOAD, state returns to HDR0.
  - The partial word is discarded and err_out is set.
  - RDREQ never times out.
- Undefined: no counter; the decoder waits indefinitely for the next byte.

Decomposition:
- Shared package bitnet_pkg holds:
  - the command localparams CMD_WR_DATA = 8'h00, CMD_WR_WEIGHT = 8'h01, CMD_WR_OP = 8'h03, CMD_RD_DATA = 8'h04;
  - the write-select enum;
  - the decoder state enum.
- One natural sub-module: word_assembler.
  - Holds the byte-index counter, shift/insert register, bytes-per-word compare and word_done pulse.
  - The FSM, address counter and readback handshake stay in the top of this block.

Test Plan:
- Op write: bytes 03 00 00 05 -> one wr_en_out with sel=3, addr=0, data=0x05, 1 cycle after byte 4; busy_out low after.
- Data write: 00 01 00, then 16 bytes 0x36..0x45 -> two strobes, sel=0:
  - addr 0, data 0x3D3C3B3A39383736;
  - addr 1, data 0x4544434241403F3E.
- Weight width: 01 00 00 plus 12 bytes 0x01..0x0C -> one strobe, sel=1, data=0x0C0B0A090807060504030201.
- Readback: 04 02 00 with rd_req_ready_in held low for 5 cycles -> rd_req_valid_out held, rd_count_out=2 stable; clears the cycle after ready is sampled high.
- Bad command 07 00 00 -> err_out=1, no strobe; a following 03 00 00 09 still writes 0x09 at addr 0.
- Reset low after 3 of 8 data payload bytes -> no strobe; after release, a fresh header is parsed correctly.
  - With PKT_TIMEOUT_EN: a stall of TIMEOUT_CYCLES mid-payload -> HDR0 and err_out=1.
